pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/sat_counter.sv | 25 ++
 rtl/pipeline_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the pipeline hazard controller: operand-forward encodings,
// the per-stage shadow record and the hazard-match helper.
package cpu_pkg;

   localparam int MAX_AW = 8;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_M   = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef struct packed {
      logic              valid;
      logic [MAX_AW-1:0] rs1;
      logic [MAX_AW-1:0] rs2;
      logic              use1;
      logic              use2;
      logic [MAX_AW-1:0] rd;
      logic              write;
      logic              load;
      logic              mem;
   } stage_t;

   // A stage produces a value that the given source needs.
   function automatic logic hazard(input stage_t s, input logic [MAX_AW-1:0] addr,
                                   input logic use_src, input logic zero_reg);
      return s.valid & s.write & (s.rd == addr) & use_src & (~zero_reg | (addr != '0));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNTWIDTH = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                inc,
   output logic [CNTWIDTH-1:0] count
);

   logic [CNTWIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) count_d = count_q + CNTWIDTH'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/forward controller for a 5-stage pipeline; tracks E, M and WB
// through shadow records and keeps stall, flush and retire counters.
module pipeline_ctrl
   import cpu_pkg::*;
#(
   parameter int ADDRESSWIDTH = 4,
   parameter int CNTWIDTH     = 16,
   parameter int FORWARDEN    = 1,
   parameter int ZEROREG      = 0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    decValid,
   input  logic [ADDRESSWIDTH-1:0] decRs1,
   input  logic [ADDRESSWIDTH-1:0] decRs2,
   input  logic                    decUse1,
   input  logic                    decUse2,
   input  logic [ADDRESSWIDTH-1:0] decRd,
   input  logic                    decWrite,
   input  logic                    decLoad,
   input  logic                    decMem,
   input  logic                    takeBranchE,
   input  logic                    memReady,
   output logic                    stallF,
   output logic                    stallD,
   output logic                    stallE,
   output logic                    stallM,
   output logic                    flushD,
   output logic                    flushE,
   output logic                    bubbleWB,
   output logic [1:0]              fwd1Sel,
   output logic [1:0]              fwd2Sel,
   output logic [CNTWIDTH-1:0]     stallCount,
   output logic [CNTWIDTH-1:0]     flushCount,
   output logic [CNTWIDTH-1:0]     retireCount
);

   localparam logic ZR  = (ZEROREG != 0);
   localparam logic FWD = (FORWARDEN != 0);

   logic [MAX_AW-1:0] rs1_x, rs2_x, rd_x;
   stage_t            e_q, m_q, wb_q, e_d, m_d, wb_d;
   logic              mem_wait, load_use;
   logic              dec_hit_e, dec_hit_m, dec_hit_wb;
   logic              unused_shadow;

   assign rs1_x = MAX_AW'(decRs1);
   assign rs2_x = MAX_AW'(decRs2);
   assign rd_x  = MAX_AW'(decRd);

   assign dec_hit_e  = hazard(e_q,  rs1_x, decUse1, ZR) | hazard(e_q,  rs2_x, decUse2, ZR);
   assign dec_hit_m  = hazard(m_q,  rs1_x, decUse1, ZR) | hazard(m_q,  rs2_x, decUse2, ZR);
   assign dec_hit_wb = hazard(wb_q, rs1_x, decUse1, ZR) | hazard(wb_q, rs2_x, decUse2, ZR);

   assign mem_wait = m_q.valid & m_q.mem & ~memReady;
   // Without forwarding the register file is the only source, so any in-flight writer blocks.
   assign load_use = FWD ? (decValid & e_q.load & dec_hit_e)
                         : (decValid & (dec_hit_e | dec_hit_m | dec_hit_wb));

   always_comb begin
      stallF   = 1'b0;
      stallD   = 1'b0;
      stallE   = 1'b0;
      stallM   = 1'b0;
      flushD   = 1'b0;
      flushE   = 1'b0;
      bubbleWB = 1'b0;
      if (reset) begin
         flushD = 1'b1;
         flushE = 1'b1;
      end else if (mem_wait) begin
         stallF   = 1'b1;
         stallD   = 1'b1;
         stallE   = 1'b1;
         stallM   = 1'b1;
         bubbleWB = 1'b1;
      end else if (takeBranchE) begin
         flushD = 1'b1;
         flushE = 1'b1;
      end else if (load_use) begin
         stallF = 1'b1;
         stallD = 1'b1;
         flushE = 1'b1;
      end
   end

   always_comb begin
      fwd1Sel = FWD_REG;
      fwd2Sel = FWD_REG;
      if (FWD && !reset) begin
         if      (hazard(m_q,  e_q.rs1, e_q.use1, ZR)) fwd1Sel = FWD_M;
         else if (hazard(wb_q, e_q.rs1, e_q.use1, ZR)) fwd1Sel = FWD_WB;
         if      (hazard(m_q,  e_q.rs2, e_q.use2, ZR)) fwd2Sel = FWD_M;
         else if (hazard(wb_q, e_q.rs2, e_q.use2, ZR)) fwd2Sel = FWD_WB;
      end
   end

   always_comb begin
      e_d  = e_q;
      m_d  = m_q;
      wb_d = wb_q;
      if (mem_wait) begin
         wb_d.valid = 1'b0;
      end else begin
         wb_d = m_q;
         m_d  = e_q;
         e_d  = '{valid: decValid & ~takeBranchE & ~load_use,
                  rs1: rs1_x, rs2: rs2_x, use1: decUse1, use2: decUse2,
                  rd: rd_x, write: decWrite, load: decLoad, mem: decMem};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         e_q  <= '0;
         m_q  <= '0;
         wb_q <= '0;
      end else begin
         e_q  <= e_d;
         m_q  <= m_d;
         wb_q <= wb_d;
      end
   end

   assign unused_shadow = ^{e_q, m_q, wb_q};

   sat_counter #(.CNTWIDTH(CNTWIDTH)) u_stall_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (stallF),
      .count (stallCount)
   );

   sat_counter #(.CNTWIDTH(CNTWIDTH)) u_flush_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (takeBranchE & ~mem_wait),
      .count (flushCount)
   );

   sat_counter #(.CNTWIDTH(CNTWIDTH)) u_retire_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (wb_q.valid & ~mem_wait),
      .count (retireCount)
   );

endmodule
